rtr_fb_pop_sched: RTL and testbench

Per-input-port pop scheduler for the router flit buffer. Each cycle it selects at most one input VC to pop, using VC occupancy, downstream credit availability, wormhole packet locking and round-robin fairness. It drives the buffer's pop_valid / pop_sel_ivc / pop_active inputs and tracks downstream credits per VC, with a 1:1 mapping of input VC to output VC. A registered output strobe is aligned with the buffer's pop_data, which is valid one cycle after pop_valid.

---
 rtl/rtr_fb_pop_sched_pkg.sv | 12 +
 rtl/rtr_fb_credit_ctr.sv | 35 +++
 rtl/rtr_fb_pop_sched.sv | 101 ++++++++++
 tb/tb_rtr_fb_pop_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rtr_fb_pop_sched_pkg.sv
// rtr_fb_pop_sched_pkg: shared constants and the credit-counter width helper for the flit-buffer pop scheduler
package rtr_fb_pop_sched_pkg;
  localparam int ERR_IDX_CREDIT_OVF = 0;
  localparam int ERR_NUM = 1;
  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clogb(input int x);
    int r;
    r = 1;
    while ((1 << r) < x) r++;
    return r;
  endfunction
endpackage

// File: rtl/rtr_fb_credit_ctr.sv
// rtr_fb_credit_ctr: per-VC downstream credit counter with saturating return, pop decrement and sticky overflow flag
//   clk, rst_n   : clock, asynchronous active-low reset (counter reloads to CREDITS)
//   i_inc        : one credit returned for this VC
//   i_dec        : one flit popped on this VC
//   o_nz         : counter is nonzero (registered value)
//   o_err        : sticky overflow, set by a return while already full
module rtr_fb_credit_ctr
  import rtr_fb_pop_sched_pkg::*;
#(
  parameter int CREDITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nz,
  output logic o_err
);
  localparam int CW = clogb(CREDITS + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CW'(CREDITS);
      r_err <= 1'b0;
    end else if (i_inc & ~i_dec) begin
      if (r_cnt == CW'(CREDITS)) r_err <= 1'b1;
      else r_cnt <= r_cnt + 1'b1;
    end else if (i_dec & ~i_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
  assign o_nz = |r_cnt;
  assign o_err = r_err;
endmodule

// File: rtl/rtr_fb_pop_sched.sv
// rtr_fb_pop_sched: per-input-port pop scheduler selecting one input VC per cycle by occupancy, credits, wormhole lock and round-robin
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_empty_ivc         : buffer per-VC empty flags
//   i_pop_tail_ivc      : tail bit of the head flit of each VC
//   i_stall             : downstream not ready, blocks all pops
//   i_credit_valid      : one credit returned this cycle
//   i_credit_sel_ovc    : one-hot VC of the returned credit
//   o_pop_active        : activity enable to the buffer
//   o_pop_valid         : pop issued this cycle (combinational)
//   o_pop_sel_ivc       : one-hot VC popped, zero when idle (combinational)
//   o_out_valid         : registered pop_valid, aligned with buffer pop_data
//   o_out_sel_ovc       : registered pop_sel_ivc
//   o_out_tail          : registered tail bit of the popped flit
//   o_credit_avail_ovc  : per-VC credit counter nonzero
//   o_errors_ovc        : per-VC sticky credit overflow
module rtr_fb_pop_sched
  import rtr_fb_pop_sched_pkg::*;
#(
  parameter int NUM_VCS = 4,
  parameter int CREDITS_PER_VC = 8,
  parameter int PACKET_LOCK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_VCS-1:0] i_empty_ivc,
  input  logic [NUM_VCS-1:0] i_pop_tail_ivc,
  input  logic               i_stall,
  input  logic               i_credit_valid,
  input  logic [NUM_VCS-1:0] i_credit_sel_ovc,
  output logic               o_pop_active,
  output logic               o_pop_valid,
  output logic [NUM_VCS-1:0] o_pop_sel_ivc,
  output logic               o_out_valid,
  output logic [NUM_VCS-1:0] o_out_sel_ovc,
  output logic               o_out_tail,
  output logic [NUM_VCS-1:0] o_credit_avail_ovc,
  output logic [NUM_VCS-1:0] o_errors_ovc
);
  localparam int PW = NUM_VCS > 1 ? $clog2(NUM_VCS) : 1;
  logic [NUM_VCS-1:0] w_nz, w_elig, w_grant, w_lockmask, r_out_sel;
  logic [PW-1:0] r_ptr, r_locked_vc, w_gidx, w_ptr_nxt;
  logic r_lock, w_found, w_tail, w_adv, r_out_valid, r_out_tail;
  int w_k;
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_ctr
    rtr_fb_credit_ctr #(.CREDITS(CREDITS_PER_VC)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (i_credit_valid & i_credit_sel_ovc[v]),
      .i_dec (w_grant[v]),
      .o_nz  (w_nz[v]),
      .o_err (o_errors_ovc[v])
    );
  end
  // While a packet holds the lock, only its VC may compete; if it stalls, everyone waits.
  assign w_lockmask = r_lock ? (NUM_VCS'(1) << r_locked_vc) : '1;
  assign w_elig = ~i_empty_ivc & w_nz & w_lockmask & {NUM_VCS{~i_stall}};
  always_comb begin
    w_grant = '0;
    w_gidx = '0;
    w_found = 1'b0;
    w_k = 0;
    for (int i = 0; i < NUM_VCS; i++) begin
      w_k = (int'(r_ptr) + i) % NUM_VCS;
      if (!w_found && w_elig[w_k]) begin
        w_found = 1'b1;
        w_grant[w_k] = 1'b1;
        w_gidx = PW'(w_k);
      end
    end
  end
  assign w_tail = |(w_grant & i_pop_tail_ivc);
  // With locking the pointer only moves at packet boundaries, so fairness is per packet.
  assign w_adv = w_found & ((PACKET_LOCK == 0) | w_tail);
  assign w_ptr_nxt = (int'(w_gidx) == NUM_VCS - 1) ? '0 : w_gidx + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_lock <= 1'b0;
      r_locked_vc <= '0;
      r_out_valid <= 1'b0;
      r_out_sel <= '0;
      r_out_tail <= 1'b0;
    end else begin
      if (w_adv) r_ptr <= w_ptr_nxt;
      if (PACKET_LOCK != 0 && w_found) begin
        r_lock <= ~w_tail;
        if (!w_tail) r_locked_vc <= w_gidx;
      end
      r_out_valid <= w_found;
      r_out_sel <= w_grant;
      r_out_tail <= w_found & w_tail;
    end
  end
  assign o_pop_valid = w_found;
  assign o_pop_sel_ivc = w_grant;
  assign o_out_valid = r_out_valid;
  assign o_out_sel_ovc = r_out_sel;
  assign o_out_tail = r_out_tail;
  assign o_credit_avail_ovc = w_nz;
  assign o_pop_active = (|(~i_empty_ivc)) | r_out_valid;
endmodule

// File: tb/tb_rtr_fb_pop_sched.sv
// tb_rtr_fb_pop_sched: directed plus random stimulus checked against a queue-based buffer/credit model
module tb_rtr_fb_pop_sched;
  localparam int N = 4;
  localparam int CR = 2;
  localparam int PL = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] empty = '1, tail = '0, csel = '0;
  logic stall = 1'b0, cv = 1'b0;
  logic pop_active, pop_valid, out_valid, out_tail;
  logic [N-1:0] pop_sel, out_sel, cavail, errs;
  rtr_fb_pop_sched #(.NUM_VCS(N), .CREDITS_PER_VC(CR), .PACKET_LOCK(PL)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_empty_ivc        (empty),
    .i_pop_tail_ivc     (tail),
    .i_stall            (stall),
    .i_credit_valid     (cv),
    .i_credit_sel_ovc   (csel),
    .o_pop_active       (pop_active),
    .o_pop_valid        (pop_valid),
    .o_pop_sel_ivc      (pop_sel),
    .o_out_valid        (out_valid),
    .o_out_sel_ovc      (out_sel),
    .o_out_tail         (out_tail),
    .o_credit_avail_ovc (cavail),
    .o_errors_ovc       (errs)
  );
  always #5 clk = ~clk;
  bit q[N][$];
  int cnt[N];
  bit err[N];
  int ptr, lvc;
  bit lock, eov, etail;
  logic [N-1:0] esel;
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic mreset();
    for (int v = 0; v < N; v++) begin
      cnt[v] = CR;
      err[v] = 1'b0;
    end
    ptr = 0;
    lvc = 0;
    lock = 1'b0;
    eov = 1'b0;
    etail = 1'b0;
    esel = '0;
  endtask
  task automatic push_pkt(input int v, input int len);
    for (int i = 0; i < len; i++) q[v].push_back(i == len - 1);
  endtask
  function automatic logic [N-1:0] m_avail();
    logic [N-1:0] r;
    for (int v = 0; v < N; v++) r[v] = cnt[v] != 0;
    return r;
  endfunction
  function automatic logic [N-1:0] m_err();
    logic [N-1:0] r;
    for (int v = 0; v < N; v++) r[v] = err[v];
    return r;
  endfunction
  // One cycle, entered just after a falling edge: drive, check, clock, update model.
  task automatic cyc(input bit st, input bit c_v, input int c_idx);
    int g, k;
    logic [N-1:0] gsel;
    bit gtail, inc, dec;
    stall = st;
    cv = c_v;
    csel = c_v ? N'(1) << c_idx : '0;
    for (int v = 0; v < N; v++) begin
      empty[v] = q[v].size() == 0;
      tail[v] = empty[v] ? 1'b0 : q[v][0];
    end
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      k = (ptr + i) % N;
      if (g < 0 && q[k].size() > 0 && cnt[k] > 0 && !st && (!lock || k == lvc)) g = k;
    end
    gsel = g >= 0 ? N'(1) << g : '0;
    gtail = g >= 0 ? q[g][0] : 1'b0;
    chk("pop_valid", 32'(pop_valid), 32'(g >= 0));
    chk("pop_sel", 32'(pop_sel), 32'(gsel));
    chk("out_valid", 32'(out_valid), 32'(eov));
    chk("out_sel", 32'(out_sel), 32'(esel));
    chk("out_tail", 32'(out_tail), 32'(etail));
    chk("credit_avail", 32'(cavail), 32'(m_avail()));
    chk("errors", 32'(errs), 32'(m_err()));
    chk("pop_active", 32'(pop_active), 32'((|(~empty)) | eov));
    @(posedge clk);
    eov = g >= 0;
    esel = gsel;
    etail = gtail;
    if (g >= 0) begin
      void'(q[g].pop_front());
      if (gtail || PL == 0) ptr = (g + 1) % N;
      if (PL != 0) begin
        lock = !gtail;
        if (!gtail) lvc = g;
      end
    end
    for (int v = 0; v < N; v++) begin
      dec = g == v;
      inc = c_v && c_idx == v;
      if (inc && !dec) begin
        if (cnt[v] == CR) err[v] = 1'b1;
        else cnt[v]++;
      end else if (dec && !inc) cnt[v]--;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
  endtask
  initial begin
    mreset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_credit_avail", 32'(cavail), 32'hf);
    chk("rst_errors", 32'(errs), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    rst_n = 1'b1;
    idle(1);
    // Two single-flit packets, then returned credits to refill
    push_pkt(0, 1);
    push_pkt(2, 1);
    idle(3);
    cyc(0, 1, 0);
    cyc(0, 1, 2);
    // Locked 3-flit packet on VC1 versus single flit on VC3
    push_pkt(1, 3);
    push_pkt(3, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    idle(2);
    cyc(0, 1, 1);
    cyc(0, 1, 3);
    // Credit starvation on VC0, then one return unblocks the next cycle
    push_pkt(0, 3);
    idle(4);
    cyc(0, 1, 0);
    idle(2);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    // Overflow on a full VC2, then simultaneous pop and return
    cyc(0, 1, 2);
    push_pkt(2, 1);
    cyc(0, 1, 2);
    idle(1);
    // Stall mid-packet
    push_pkt(0, 3);
    push_pkt(3, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    // Reset mid-packet: lock, pointer and credits drop at once
    push_pkt(1, 3);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_credit_avail", 32'(cavail), 32'hf);
    chk("mid_rst_errors", 32'(errs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mreset();
    idle(8);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int v;
        v = $urandom_range(0, N - 1);
        if (q[v].size() < 8) push_pkt(v, $urandom_range(1, 3));
      end
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, N - 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
